// File: rtl/yolo_pkg.sv
// Shared constants for the requantize + leaky ReLU stage that follows conv_3x3.
// No ports; imported by quant_leaky_relu and its testbench.
package yolo_pkg;

  localparam int ACC_W     = 32;  // signed accumulator width from conv_3x3
  localparam int MULT_W    = 16;  // unsigned requantization multiplier width
  localparam int OUT_W     = 8;   // signed int8 activation width
  localparam int LEAKY_NUM = 13;  // negative slope numerator (13/128 ~ 0.1)
  localparam int LEAKY_SH  = 7;   // negative slope denominator exponent
  localparam int LATENCY   = 4;   // valid_in -> data_valid, in cycles
  localparam int SHIFT_W   = 6;   // right-shift control width (0..47)
  localparam int SAT_W     = 16;  // saturation counter width

  // Width of signed(acc) * zero-extended(mult).
  function automatic int prod_width(input int acc_w, input int mult_w);
    return acc_w + mult_w + 1;
  endfunction

endpackage

// File: rtl/quant_leaky_relu_round_shift.sv
// Combinational rounding arithmetic right shift (round half up).
// Ports:
//   din   - signed operand
//   shift - shift amount; 0 passes din through unchanged
//   dout  - (din + 2^(shift-1)) >>> shift, same width as din
module round_shift #(
  parameter int W       = 49,
  parameter int SHIFT_W = 6
) (
  input  logic signed [W-1:0]       din,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [W-1:0]       dout
);

  // One guard bit so adding the half-LSB can never wrap.
  logic signed [W:0] din_ext;
  logic signed [W:0] half;
  logic signed [W:0] sum;
  logic signed [W:0] shifted;

  always_comb begin
    din_ext = {din[W-1], din};
    half    = '0;
    if (shift != '0) begin
      half = $signed({{W{1'b0}}, 1'b1} << (shift - 1'b1));
    end
    sum     = din_ext + half;
    shifted = sum >>> shift;
    dout    = shifted[W-1:0];
  end

endmodule

// File: rtl/quant_leaky_relu.sv
// Four-stage requantize + leaky ReLU pipeline, one beat per cycle, no backpressure.
//   S1: prod = acc_in * mult            S2: rounding right shift by 'shift'
//   S3: optional x13/128 on negatives   S4: clamp to int8, count saturations
// Ports:
//   clk, rst (async, active-low)
//   valid_in, acc_in           - input beat from conv_3x3
//   mult, shift, leaky_en      - quasi-static config, sampled in S1/S2/S3
//   sat_clr                    - synchronous clear of sat_count (wins over increment)
//   out, data_valid            - result, valid 4 cycles after its valid_in
//   busy                       - any stage holds a beat
//   sat_count                  - saturating count of clamped output beats
module quant_leaky_relu #(
  parameter int ACC_W  = yolo_pkg::ACC_W,
  parameter int MULT_W = yolo_pkg::MULT_W,
  parameter int OUT_W  = yolo_pkg::OUT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic signed [ACC_W-1:0]    acc_in,
  input  logic        [MULT_W-1:0]   mult,
  input  logic        [5:0]          shift,
  input  logic                       leaky_en,
  input  logic                       sat_clr,
  output logic signed [OUT_W-1:0]    out,
  output logic                       data_valid,
  output logic                       busy,
  output logic        [15:0]         sat_count
);

  import yolo_pkg::*;

  localparam int PROD_W = prod_width(ACC_W, MULT_W);
  // x13 needs four more bits than the rounded product.
  localparam int LK_W   = PROD_W + 4;

  localparam logic signed [LK_W-1:0]  LK_NUM  = LK_W'(LEAKY_NUM);
  localparam logic signed [LK_W-1:0]  OUT_MAX = LK_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [LK_W-1:0]  OUT_MIN = LK_W'(-(2 ** (OUT_W - 1)));
  localparam logic        [SAT_W-1:0] SAT_MAX = '1;

  logic [LATENCY-1:0] valid_d, valid_q;

  logic signed [PROD_W-1:0] acc_ext, mult_ext;
  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic signed [PROD_W-1:0] rnd_w, rnd_d, rnd_q;
  logic signed [LK_W-1:0]   rnd_ext, lk_mul, lk_calc, lk_d, lk_q;
  logic signed [OUT_W-1:0]  clamp_w, out_d, out_q;
  logic                     sat_hit;
  logic [SAT_W-1:0]         sat_count_d, sat_count_q;

  round_shift #(
    .W       (PROD_W),
    .SHIFT_W (SHIFT_W)
  ) u_round_shift (
    .din   (prod_q),
    .shift (shift),
    .dout  (rnd_w)
  );

  // Each stage loads only when the beat arriving at it is valid, so idle
  // stages keep their data and nothing toggles between bursts.
  always_comb begin
    valid_d = {valid_q[LATENCY-2:0], valid_in};

    acc_ext  = PROD_W'(acc_in);
    mult_ext = $signed({{(PROD_W - MULT_W){1'b0}}, mult});
    prod_d   = valid_in ? (acc_ext * mult_ext) : prod_q;

    rnd_d = valid_q[0] ? rnd_w : rnd_q;

    rnd_ext = LK_W'(rnd_q);
    lk_mul  = rnd_ext * LK_NUM;
    lk_calc = rnd_ext;
    if (leaky_en && rnd_q[PROD_W-1]) begin
      lk_calc = lk_mul >>> LEAKY_SH;
    end
    lk_d = valid_q[1] ? lk_calc : lk_q;

    sat_hit = 1'b0;
    clamp_w = lk_q[OUT_W-1:0];
    if (lk_q > OUT_MAX) begin
      sat_hit = 1'b1;
      clamp_w = OUT_MAX[OUT_W-1:0];
    end else if (lk_q < OUT_MIN) begin
      sat_hit = 1'b1;
      clamp_w = OUT_MIN[OUT_W-1:0];
    end
    out_d = valid_q[2] ? clamp_w : out_q;

    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (valid_q[2] && sat_hit && (sat_count_q != SAT_MAX)) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      out_q       <= '0;
      sat_count_q <= '0;
    end else begin
      valid_q     <= valid_d;
      out_q       <= out_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Intermediate data is always qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    rnd_q  <= rnd_d;
    lk_q   <= lk_d;
  end

  assign out        = out_q;
  assign data_valid = valid_q[LATENCY-1];
  assign busy       = |valid_q;
  assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_quant_leaky_relu.sv
module tb_quant_leaky_relu;
  import yolo_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     valid_in = 1'b0;
  logic signed [ACC_W-1:0]  acc_in = '0;
  logic        [MULT_W-1:0] mult = '0;
  logic        [5:0]        shift = '0;
  logic                     leaky_en = 1'b0;
  logic                     sat_clr = 1'b0;
  logic signed [OUT_W-1:0]  out;
  logic                     data_valid;
  logic                     busy;
  logic        [15:0]       sat_count;

  quant_leaky_relu dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .acc_in     (acc_in),
    .mult       (mult),
    .shift      (shift),
    .leaky_en   (leaky_en),
    .sat_clr    (sat_clr),
    .out        (out),
    .data_valid (data_valid),
    .busy       (busy),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [OUT_W-1:0] val;
    int                      cyc;
    int                      id;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_sat = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every presented output beat.
  always @(negedge clk) begin
    exp_t e;
    if (rst && data_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_valid: got data_valid=1 out=%0d, expected no pending beat", out);
      end else begin
        e = sb.pop_front();
        check($sformatf("out_id%0d", e.id), out, e.val);
        check($sformatf("latency_id%0d", e.id), cyc - e.cyc, LATENCY);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int ev, input bit sat, input int id);
    exp_t e;
    valid_in = 1'b1;
    acc_in   = ACC_W'(a);
    e.val    = OUT_W'(ev);
    e.cyc    = cyc;
    e.id     = id;
    sb.push_back(e);
    if (sat) exp_sat++;
    step();
    valid_in = 1'b0;
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL drain_id%0d: got busy=%0b pending=%0d after 50 cycles, expected idle", id, busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input int a, input int m, input int s, input bit lk,
                         input int ev, input bit sat, input int id);
    mult     = MULT_W'(m);
    shift    = 6'(s);
    leaky_en = lk;
    send(a, ev, sat, id);
    drain(id);
  endtask

  initial begin
    #12;
    check("reset_out", out, 0);
    check("reset_data_valid", data_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_sat_count", sat_count, 0);
    step();
    rst = 1'b1;
    step();
    step();

    // Single beat, then idle with a changing acc_in: out must hold.
    run_vec(14, 1, 0, 0, 14, 0, 0);
    acc_in = ACC_W'(99);
    repeat (5) step();
    check("out_hold_idle", out, 14);

    // acc, mult, shift, leaky, expected, saturates
    run_vec(100, 3, 2, 0, 75, 0, 1);
    run_vec(-5, 1, 1, 0, -2, 0, 2);
    run_vec(3, 1, 1, 0, 2, 0, 3);
    run_vec(-3, 1, 1, 0, -1, 0, 4);
    run_vec(-100, 1, 0, 1, -11, 0, 5);
    run_vec(-100, 1, 0, 0, -100, 0, 6);
    run_vec(-1, 1, 0, 1, -1, 0, 7);
    run_vec(-1000, 1, 0, 1, -102, 0, 8);
    run_vec(127, 1, 0, 0, 127, 0, 9);
    run_vec(-128, 1, 0, 0, -128, 0, 10);
    run_vec(2147483647, 65535, 47, 0, 1, 0, 11);
    run_vec(-2147483647 - 1, 65535, 47, 0, -1, 0, 12);
    check("sat_count_no_clamp", sat_count, exp_sat);

    run_vec(1000, 1, 0, 0, 127, 1, 13);
    run_vec(-1000, 1, 0, 0, -128, 1, 14);
    check("sat_count_two", sat_count, exp_sat);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    exp_sat = 0;
    check("sat_count_cleared", sat_count, exp_sat);

    run_vec(128, 1, 0, 0, 127, 1, 15);
    run_vec(-129, 1, 0, 0, -128, 1, 16);
    run_vec(-10000, 1, 0, 1, -128, 1, 17);
    check("sat_count_three", sat_count, exp_sat);

    // Clear in the same cycle S4 loads a clamped beat: clear wins.
    mult = 16'd1; shift = 6'd0; leaky_en = 1'b0;
    send(500, 127, 0, 18);
    step();
    step();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    exp_sat = 0;
    drain(18);
    check("sat_clr_wins", sat_count, exp_sat);

    // 40 back-to-back beats.
    for (int i = 0; i < 40; i++) begin
      if (i > 0) check($sformatf("busy_stream_%0d", i), busy, 1);
      send(i, i, 0, 100 + i);
    end
    drain(140);

    // Reset in the middle of a 10-beat stream.
    for (int b = 0; b < 7; b++) begin
      if (b == 0)      send(300, 127, 1, 200);
      else if (b == 1) send(-300, -128, 1, 201);
      else             send(b, b, 0, 200 + b);
    end
    rst = 1'b0;
    sb.delete();
    exp_sat = 0;
    #1;
    check("midrst_data_valid", data_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sat_count", sat_count, 0);
    check("midrst_out", out, 0);
    for (int b = 7; b < 10; b++) begin
      valid_in = 1'b1;
      acc_in   = ACC_W'(b);
      step();
    end
    valid_in = 1'b0;
    rst = 1'b1;
    repeat (10) step();
    check("post_rst_busy", busy, 0);
    send(55, 55, 0, 300);
    drain(300);
    check("post_rst_sat_count", sat_count, exp_sat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/quant_leaky_relu.md
QUANT_LEAKY_RELU -- requirements
Module: quant_leaky_relu

Interface
REQ-001 ACC_W, default 32, accumulator width of conv_3x3 output (signed).
REQ-002 MULT_W, default 16, requantization multiplier width (unsigned).
REQ-003 OUT_W, default 8, output activation width (signed int8).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 valid_in  input  1  acc_in beat qualifier; driven by conv_3x3 data_valid.
REQ-007 acc_in  input  ACC_W  signed accumulator from conv_3x3 out.
REQ-008 mult  input  MULT_W  unsigned scale multiplier, quasi-static.
REQ-009 shift  input  6  right-shift amount 0..47, quasi-static.
REQ-010 leaky_en  input  1  1 = leaky ReLU on negatives; 0 = linear.
REQ-011 sat_clr  input  1  synchronous clear of sat_count.
REQ-012 out  output  OUT_W  signed requantized activation.
REQ-013 data_valid  output  1  out qualifier, one cycle per accepted beat.
REQ-014 busy  output  1  high while any pipeline stage holds a valid beat.
REQ-015 sat_count  output  16  count of saturated output beats.

Function
REQ-016 Pipeline SHALL be 4 stages, no backpressure; every valid_in beat SHALL produce data_valid exactly 4 cycles later, in order, full throughput (1 beat/cycle).
REQ-017 S1: prod = signed(acc_in) * zero-extended mult, 49-bit signed, registered.
REQ-018 S2: rnd = (prod + 2^(shift-1)) >>> shift for shift>0; rnd = prod for shift=0; arithmetic shift, round-half-up.
REQ-019 S3: if leaky_en and rnd<0: lk = (rnd*13) >>> 7 (floor); else lk = rnd.
REQ-020 S4: out = clamp(lk, -128, 127), registered.
REQ-021 Valid bit SHALL travel with each stage; stages with valid=0 SHALL hold data (no toggling on idle).
REQ-022 busy SHALL equal OR of the 4 stage valid bits.
REQ-023 sat_count SHALL increment when S4 loads a valid beat that clamped; SHALL stick at 16'hFFFF.
REQ-024 sat_clr SHALL zero sat_count next cycle; clear wins over simultaneous increment.
REQ-025 mult/shift/leaky_en SHALL be sampled per stage as data passes; changing them while busy=1 yields undefined values for in-flight beats only, never lost/extra data_valid.
REQ-026 valid_in=0 beats SHALL be ignored regardless of acc_in.

Reset
REQ-027 rst=0 SHALL asynchronously clear all stage valid bits, data_valid, out, sat_count to 0; busy reads 0.
REQ-028 Reset mid-stream SHALL discard all in-flight beats; no data_valid until new beats traverse 4 stages after release.
REQ-029 Data registers other than out need no reset.

Structure
REQ-030 ACC_W, MULT_W, OUT_W, LEAKY_NUM=13, LEAKY_SH=7, LATENCY=4 SHALL live in the shared yolo package.
REQ-031 One sub-module, round_shift (S2 rounding arithmetic shift, combinational), SHALL be instantiated; rest inline.

Verification
REQ-032 acc=14, mult=1, shift=0, leaky_en=0 -> out=14 exactly 4 cycles after valid_in, data_valid one cycle wide.
REQ-033 acc=100, mult=3, shift=2 -> out=75; acc=-5, mult=1, shift=1 -> out=-2.
REQ-034 acc=-100, mult=1, shift=0, leaky_en=1 -> out=-11; same with leaky_en=0 -> out=-100.
REQ-035 acc=1000 and acc=-1000, mult=1, shift=0, leaky_en=0 -> out=127 then -128, sat_count=2; sat_clr -> 0.
REQ-036 40 back-to-back beats acc=0..39, mult=1, shift=0 -> 40 consecutive data_valid, out=0..39 in order, busy high throughout.
REQ-037 Stream 10 beats, assert rst after beat 6 -> data_valid/busy/sat_count 0 immediately; no stale outputs after release.
